seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial pattern detector: next generation of the fixed 10110 Mealy detector. Pattern value and length, overlap policy and Mealy/Moore output timing are elaboration-time parameters. Adds an input-valid qualifier and a saturating match counter with synchronous clear. Sits on a 1-bit serial stream, one bit per qualified clock, and flags every completed occurrence of the pattern.

## Interface
- `W`, 5: pattern length in bits, 2..16.
- `PATTERN`, 5'b10110: pattern; MSB is the first bit received.
- `OVERLAP`, 1: 1 = overlapping detection, 0 = non-overlapping (restart from empty after a match).
- `MOORE`, 0: 0 = Mealy (combinational `out`), 1 = Moore (registered `out`, one cycle later).
- `CNT_W`, 8: match counter width.

- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_seq` is sampled only when high.
- `in_seq` input 1: serial data bit.
- `cnt_clr` input 1: synchronous clear of `match_cnt`.
- `out` output 1: match pulse, one cycle per match.
- `match_cnt` output CNT_W: saturating count of matches.

## Operation
- State `s` = number of pattern bits currently matched, range 0..W-1, encoded in $clog2(W) bits. Reset value 0.
- Transition on `in_valid`=1: `s' = delta(s, in_seq)`, where delta is the KMP automaton for PATTERN: extend if `in_seq` equals pattern bit `W-1-s`, otherwise fall back through the failure function to the longest matched prefix that is also a suffix of the received bits.
- Match: `in_valid`=1, `s`=W-1, `in_seq`=PATTERN[0].
- After a match, `s` becomes `border(W)` (longest proper prefix of PATTERN that is also a suffix) if OVERLAP=1, else 0.
- `in_valid`=0: `s` holds and no match is possible. Gaps never break a partial match.
- Mealy: `out` = match, combinational from `s`, `in_valid`, `in_seq`; forced 0 while `rst` is high.
- Moore: `out` is a register loaded with match each cycle; reset value 0.
- Counter: increments on match, saturates at 2^CNT_W-1 and holds there.
  - `cnt_clr` alone sets it to 0.
  - `cnt_clr` together with a match sets it to 1 (the match is not lost).
  - Reset value 0.
- Reset mid-pattern: `s`=0 immediately (asynchronous); partial progress is discarded; no match is reported for bits completed across the reset.

## Timing
- Mealy: `out` is high in the same cycle the final bit is presented, before the sampling edge. `match_cnt` updates at that edge.
- Moore: `out` is high for the one cycle after the edge that sampled the final bit. `match_cnt` updates at the same edge, so it is already incremented while `out` is high.
- Back-to-back matches (for example PATTERN=111 with OVERLAP=1) produce `out` high on consecutive qualified cycles; there is no dead cycle.
- Throughput: one bit per clock; no stalls and no backpressure.

## Structure
- Package `seq_det_pkg`:
  - elaboration-time functions `seq_next(pattern, w, s, b)` and `seq_border(pattern, w)`, computing the KMP next-state and border values;
  - a localparam type for state width derived from W.
- The next-state logic is built as a generated lookup from those functions. No hand-written per-pattern case statements.
- One sub-module, `seq_match_counter`: saturating counter with synchronous clear and count-wins-over-clear rule, parameter CNT_W.

## Test plan
- Default parameters, stream 1,0,1,1,0,1,0,1,1,0 with `in_valid` always high -> `out` pulses on bits 5 and 10; `match_cnt`=2.
- Stream 1,0,1,1,0,1,1,0 -> OVERLAP=1 pulses on bits 5 and 8 (`match_cnt`=2); OVERLAP=0 pulses only on bit 5 (`match_cnt`=1).
- Same stream in MOORE=1 vs MOORE=0 -> each Moore pulse lags the Mealy pulse by exactly one clock and has identical count.
- W=3, PATTERN=3'b111, input 1,1,1,1,1 -> OVERLAP=1 pulses on bits 3, 4, 5; OVERLAP=0 pulses on bit 3 only.
- 1,0,1,1 then `in_valid` low for 3 cycles, then 0 -> match on the final bit. Repeat with `rst` pulsed during the gap -> no match.
- CNT_W=2, six matches -> `match_cnt` saturates at 3. `cnt_clr` asserted in the cycle of a match -> `match_cnt`=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial pattern detector: elaboration-time
// KMP next-state / border functions and the state-width helper.
package seq_det_pkg;

    localparam int SEQ_MAX_W = 16;
    typedef logic [SEQ_MAX_W-1:0] seq_pat_t;

    // Width of the match-progress state for a pattern of length w (holds 0..w-1).
    function automatic int seq_state_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Longest prefix of the pattern that is a suffix of (first s pattern bits, b).
    // A result of w means the pattern just completed.
    function automatic int seq_next(input seq_pat_t pattern, input int w, input int s, input logic b);
        int   best;
        int   j;
        logic ok;
        logic t;
        best = 0;
        for (int k = 1; k <= s + 1; k++) begin
            if (k <= w) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    j = s + 1 - k + i;
                    t = (j == s) ? b : pattern[w-1-j];
                    if (t != pattern[w-1-i]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the whole pattern that is also its suffix.
    function automatic int seq_border(input seq_pat_t pattern, input int w);
        int   best;
        logic ok;
        best = 0;
        for (int k = 1; k < w; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++)
                if (pattern[w-1-i] != pattern[k-1-i]) ok = 1'b0;
            if (ok) best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; a clear in the same cycle as a match yields 1.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= inc ? CNT_W'(1) : '0;
        else if (inc && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_detector.sv
// Parametrised serial pattern detector: KMP automaton built as a generated
// lookup table, Mealy or Moore match pulse, saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int           W       = 5,
    parameter logic [W-1:0] PATTERN = 5'b10110,
    parameter bit           OVERLAP = 1'b1,
    parameter bit           MOORE   = 1'b0,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_seq,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int SW     = seq_state_w(W);
    localparam int BORDER = seq_border(seq_pat_t'(PATTERN), W);
    typedef logic [SW-1:0] state_t;

    logic [W-1:0][1:0][SW-1:0] nxt_lut;
    logic [W-1:0][1:0]         hit_lut;

    // A completed pattern never becomes a state; it restarts at the border or at 0.
    for (genvar gs = 0; gs < W; gs++) begin : g_state
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            localparam int NX = seq_next(seq_pat_t'(PATTERN), W, gs, gb[0]);
            localparam int RS = (NX == W) ? (OVERLAP ? BORDER : 0) : NX;
            assign hit_lut[gs][gb] = (NX == W);
            assign nxt_lut[gs][gb] = SW'(RS);
        end
    end

    state_t s, s_nxt;
    logic   match;
    logic   out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s     <= '0;
            out_q <= 1'b0;
        end else begin
            s     <= s_nxt;
            out_q <= match;
        end
    end

    always_comb begin
        s_nxt = s;
        if (in_valid) s_nxt = nxt_lut[s][in_seq];
    end

    always_comb begin
        match = in_valid & hit_lut[s][in_seq];
        out   = MOORE ? out_q : (match & ~rst);
    end

    seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: six configurations share one stimulus
// stream; a sliding-window reference model feeds a scoreboard of expected results.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst, in_valid, in_seq, cnt_clr;
    logic out_a, out_b, out_c, out_d, out_e, out_f;
    logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d, cnt_e;
    logic [1:0] cnt_f;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // A: default, B: non-overlap, C: Moore, D/E: 111 overlap/non-overlap, F: 2-bit counter
    seq_detector_param u_a (.clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq), .cnt_clr(cnt_clr), .out(out_a), .match_cnt(cnt_a));
    seq_detector_param #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq), .cnt_clr(cnt_clr), .out(out_b), .match_cnt(cnt_b));
    seq_detector_param #(.MOORE(1'b1)) u_c (.clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq), .cnt_clr(cnt_clr), .out(out_c), .match_cnt(cnt_c));
    seq_detector_param #(.W(3), .PATTERN(3'b111), .OVERLAP(1'b1)) u_d (.clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq), .cnt_clr(cnt_clr), .out(out_d), .match_cnt(cnt_d));
    seq_detector_param #(.W(3), .PATTERN(3'b111), .OVERLAP(1'b0)) u_e (.clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq), .cnt_clr(cnt_clr), .out(out_e), .match_cnt(cnt_e));
    seq_detector_param #(.CNT_W(2)) u_f (.clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq), .cnt_clr(cnt_clr), .out(out_f), .match_cnt(cnt_f));

    typedef struct packed {
        logic [5:0]      m;
        logic [5:0][7:0] c;
    } exp_t;

    exp_t exp_q[$];

    int          mw[6]   = '{5, 5, 5, 3, 3, 5};
    logic [15:0] mp[6]   = '{16'h16, 16'h16, 16'h16, 16'h7, 16'h7, 16'h16};
    bit          mov[6]  = '{1, 0, 1, 1, 0, 1};
    int          mmax[6] = '{255, 255, 255, 255, 255, 3};
    logic [15:0] hist[6];
    int          len[6];
    int          mcnt[6];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            hist[i] = '0;
            len[i]  = 0;
            mcnt[i] = 0;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic b, input logic clr);
        exp_t        e;
        logic [15:0] nh, mask;
        logic        m;
        for (int i = 0; i < 6; i++) begin
            nh   = {hist[i][14:0], b};
            mask = 16'((32'd1 << mw[i]) - 1);
            m    = v && (len[i] + 1 >= mw[i]) && ((nh & mask) == mp[i]);
            if (v) begin
                hist[i] = nh;
                len[i]  = (m && !mov[i]) ? 0 : len[i] + 1;
            end
            if (clr) mcnt[i] = m ? 1 : 0;
            else if (m && mcnt[i] < mmax[i]) mcnt[i]++;
            e.m[i] = m;
            e.c[i] = 8'(mcnt[i]);
        end
        exp_q.push_back(e);
        in_valid = v;
        in_seq   = b;
        cnt_clr  = clr;
        #1;
        e = exp_q.pop_front();
        chk("out_a", 16'(out_a), 16'(e.m[0]));
        chk("out_b", 16'(out_b), 16'(e.m[1]));
        chk("out_d", 16'(out_d), 16'(e.m[3]));
        chk("out_e", 16'(out_e), 16'(e.m[4]));
        chk("out_f", 16'(out_f), 16'(e.m[5]));
        @(posedge clk);
        #1;
        chk("out_c_moore", 16'(out_c), 16'(e.m[2]));
        chk("cnt_a", 16'(cnt_a), 16'(e.c[0]));
        chk("cnt_b", 16'(cnt_b), 16'(e.c[1]));
        chk("cnt_c", 16'(cnt_c), 16'(e.c[2]));
        chk("cnt_d", 16'(cnt_d), 16'(e.c[3]));
        chk("cnt_e", 16'(cnt_e), 16'(e.c[4]));
        chk("cnt_f", 16'(cnt_f), 16'(e.c[5]));
        @(negedge clk);
    endtask

    task automatic drive_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    endtask

    // Reset while optionally presenting a bit that would complete a match.
    task automatic do_reset(input logic v, input logic b);
        rst      = 1'b1;
        in_valid = v;
        in_seq   = b;
        cnt_clr  = 1'b0;
        #1;
        model_reset();
        chk("rst_out_a", 16'(out_a), 16'd0);
        chk("rst_out_c", 16'(out_c), 16'd0);
        chk("rst_cnt_a", 16'(cnt_a), 16'd0);
        chk("rst_cnt_f", 16'(cnt_f), 16'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_seq = 1'b0; cnt_clr = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0, 1'b0);

        drive_bits(32'b1011010110, 10);
        chk("plan_def_cnt", 16'(cnt_a), 16'd2);
        chk("plan_moore_cnt", 16'(cnt_c), 16'd2);

        do_reset(1'b0, 1'b0);
        drive_bits(32'b10110110, 8);
        chk("plan_ov_cnt", 16'(cnt_a), 16'd2);
        chk("plan_noov_cnt", 16'(cnt_b), 16'd1);

        do_reset(1'b0, 1'b0);
        drive_bits(32'b11111, 5);
        chk("plan_111_ov_cnt", 16'(cnt_d), 16'd3);
        chk("plan_111_noov_cnt", 16'(cnt_e), 16'd1);

        // Gaps hold partial progress
        do_reset(1'b0, 1'b0);
        drive_bits(32'b1011, 4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(1)), 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("plan_gap_cnt", 16'(cnt_a), 16'd1);

        // Reset inside the gap discards progress
        do_reset(1'b0, 1'b0);
        drive_bits(32'b1011, 4);
        step(1'b0, 1'b1, 1'b0);
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("plan_gap_rst_cnt", 16'(cnt_a), 16'd0);

        // Reset coinciding with a would-be final bit masks the Mealy pulse
        drive_bits(32'b1011, 4);
        do_reset(1'b1, 1'b0);

        // Saturation and clear
        drive_bits(32'b10110110110110110110, 20);
        chk("plan_sat_f", 16'(cnt_f), 16'd3);
        chk("plan_sat_a", 16'(cnt_a), 16'd6);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("plan_clr_match", 16'(cnt_f), 16'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("plan_clr_alone", 16'(cnt_a), 16'd0);

        // Random tail to exercise other transitions against the model
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(15) == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
